// File: rtl/dmem_line_ctrl.sv
// Line-granular data memory controller: serves 128-bit line fills and
// writebacks with a fixed access latency, writebacks taking priority.
module dmem_line_ctrl #(
    parameter int LATENCY   = 5,
    parameter int MEM_LINES = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_rd,
    input  logic [25:0]  req_rd_addr,
    input  logic         req_wr,
    input  logic [25:0]  req_wr_addr,
    input  logic [127:0] wr_line,
    output logic [127:0] rd_line,
    output logic         rd_ready,
    output logic         wr_ack,
    output logic         busy
);

    localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic             op_wr;
    logic [25:0]      addr_q;
    logic [127:0]     data_q;
    logic [IDX_W-1:0] idx;
    logic             perform;

    logic [127:0] line_store [MEM_LINES];

    // Upper address bits alias onto the same line by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_q[25:IDX_W];

    assign idx     = addr_q[IDX_W-1:0];
    assign perform = (state == S_BUSY) && (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_wr    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_line  <= '0;
            rd_ready <= 1'b0;
            wr_ack   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rd_ready <= 1'b0;
            wr_ack   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_wr) begin
                        op_wr  <= 1'b1;
                        addr_q <= req_wr_addr;
                        data_q <= wr_line;
                        cnt    <= CNT_INIT;
                        state  <= S_BUSY;
                        busy   <= 1'b1;
                    end else if (req_rd) begin
                        op_wr  <= 1'b0;
                        addr_q <= req_rd_addr;
                        cnt    <= CNT_INIT;
                        state  <= S_BUSY;
                        busy   <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (cnt == '0) begin
                        state <= S_DONE;
                        if (op_wr) begin
                            wr_ack <= 1'b1;
                        end else begin
                            rd_ready <= 1'b1;
                            rd_line  <= line_store[idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // Turnaround cycle: requester drops its request here.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Store is deliberately unreset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (perform && op_wr) begin
            line_store[idx] <= data_q;
        end
    end

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Bench for dmem_line_ctrl: directed boundary cases plus randomized traffic
// checked against a line-store model and latency rules.
module tb_dmem_line_ctrl;

    localparam int LAT = 5;
    localparam int ML  = 256;

    logic         clk = 1'b0;
    logic         reset;

    logic         req_rd, req_wr;
    logic [25:0]  req_rd_addr, req_wr_addr;
    logic [127:0] wr_line, rd_line;
    logic         rd_ready, wr_ack, busy;

    logic         l1_req_rd, l1_req_wr;
    logic [25:0]  l1_req_rd_addr, l1_req_wr_addr;
    logic [127:0] l1_wr_line, l1_rd_line;
    logic         l1_rd_ready, l1_wr_ack, l1_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] model_mem [int];
    logic [127:0] last_rd;

    always #5 clk = ~clk;

    dmem_line_ctrl #(.LATENCY(LAT), .MEM_LINES(ML)) dut (
        .clk(clk), .reset(reset),
        .req_rd(req_rd), .req_rd_addr(req_rd_addr),
        .req_wr(req_wr), .req_wr_addr(req_wr_addr), .wr_line(wr_line),
        .rd_line(rd_line), .rd_ready(rd_ready), .wr_ack(wr_ack), .busy(busy)
    );

    dmem_line_ctrl #(.LATENCY(1), .MEM_LINES(ML)) dut_l1 (
        .clk(clk), .reset(reset),
        .req_rd(l1_req_rd), .req_rd_addr(l1_req_rd_addr),
        .req_wr(l1_req_wr), .req_wr_addr(l1_req_wr_addr), .wr_line(l1_wr_line),
        .rd_line(l1_rd_line), .rd_ready(l1_rd_ready), .wr_ack(l1_wr_ack), .busy(l1_busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Caller guarantees the main DUT is idle on entry.
    task automatic do_write(input logic [25:0] a, input logic [127:0] d);
        int k = 0;
        bit seen = 0;
        req_wr = 1'b1; req_wr_addr = a; wr_line = d;
        while (!seen && k < 40) begin
            tick();
            k++;
            if (k == 1) begin
                req_wr_addr = 26'($urandom);
                wr_line     = rand128();
            end
            if (wr_ack) seen = 1;
        end
        check("wr_seen", 128'(seen), 128'(1));
        check("wr_lat", 128'(k), 128'(LAT + 1));
        check("wr_no_rd", 128'(rd_ready), 128'(0));
        check("wr_busy_pulse", 128'(busy), 128'(1));
        req_wr = 1'b0;
        model_mem[int'(a) % ML] = d;
        tick();
        check("wr_ack_drop", 128'(wr_ack), 128'(0));
        check("wr_busy_idle", 128'(busy), 128'(0));
    endtask

    task automatic do_read(input logic [25:0] a);
        int k = 0;
        bit seen = 0;
        req_rd = 1'b1; req_rd_addr = a;
        while (!seen && k < 40) begin
            tick();
            k++;
            if (k == 1) req_rd_addr = 26'($urandom);
            if (rd_ready) seen = 1;
            else check("rd_line_hold", rd_line, last_rd);
        end
        check("rd_seen", 128'(seen), 128'(1));
        check("rd_lat", 128'(k), 128'(LAT + 1));
        check("rd_no_wr", 128'(wr_ack), 128'(0));
        last_rd = model_mem[int'(a) % ML];
        check("rd_data", rd_line, last_rd);
        req_rd = 1'b0;
        tick();
        check("rd_ready_drop", 128'(rd_ready), 128'(0));
        check("rd_busy_idle", 128'(busy), 128'(0));
        check("rd_line_after", rd_line, last_rd);
    endtask

    initial begin
        int k;
        bit seen, both, bad;
        logic [127:0] d;
        int idx_pool [8];

        reset = 1'b0;
        req_rd = 0; req_wr = 0; req_rd_addr = '0; req_wr_addr = '0; wr_line = '0;
        l1_req_rd = 0; l1_req_wr = 0; l1_req_rd_addr = '0; l1_req_wr_addr = '0; l1_wr_line = '0;
        last_rd = '0;
        repeat (3) tick();
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_busy", 128'(busy), 128'(0));
            check("idle_rdy", 128'(rd_ready), 128'(0));
            check("idle_ack", 128'(wr_ack), 128'(0));
            check("idle_line", rd_line, 128'(0));
        end

        // Write then read, same line.
        do_write(26'h10, 128'h0123456789ABCDEF0123456789ABCDEF);
        do_read(26'h10);

        // Simultaneous requests: write first, read follows.
        d = {4{32'hAAAAAAAA}};
        req_wr = 1; req_wr_addr = 26'h20; wr_line = d;
        req_rd = 1; req_rd_addr = 26'h20;
        k = 0; seen = 0; both = 0;
        while (!seen && k < 40) begin
            tick(); k++;
            if (wr_ack && rd_ready) both = 1;
            if (rd_ready) check("simul_rd_early", 128'(1), 128'(0));
            if (wr_ack) seen = 1;
        end
        check("simul_wr_lat", 128'(k), 128'(LAT + 1));
        req_wr = 0;
        model_mem[32'h20] = d;
        seen = 0;
        while (!seen && k < 60) begin
            tick(); k++;
            if (wr_ack && rd_ready) both = 1;
            if (rd_ready) seen = 1;
        end
        check("simul_rd_lat", 128'(k), 128'(2 * LAT + 3));
        check("simul_rd_data", rd_line, d);
        check("simul_not_both", 128'(both), 128'(0));
        last_rd = d;
        req_rd = 0;
        tick();
        check("simul_idle", 128'(busy), 128'(0));

        // Aliasing: upper address bits ignored.
        do_write(26'h105, {4{32'h55555555}});
        do_read(26'h005);

        // Reset mid-write loses the write.
        do_write(26'h30, {4{32'h11111111}});
        req_wr = 1; req_wr_addr = 26'h30; wr_line = '1;
        tick();
        req_wr = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_ack", 128'(wr_ack), 128'(0));
        check("rst_rdy", 128'(rd_ready), 128'(0));
        check("rst_line", rd_line, 128'(0));
        last_rd = '0;
        tick(); tick();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr_ack || busy) bad = 1;
        end
        check("rst_no_ack", 128'(bad), 128'(0));
        do_read(26'h30);

        // LATENCY=1 instance: write a line, then back-to-back reads.
        l1_req_wr = 1; l1_req_wr_addr = 26'h7; l1_wr_line = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        k = 0; seen = 0;
        while (!seen && k < 10) begin
            tick(); k++;
            if (l1_wr_ack) seen = 1;
        end
        check("l1_wr_lat", 128'(k), 128'(2));
        l1_req_wr = 0;
        tick();
        check("l1_wr_idle", 128'(l1_busy), 128'(0));
        l1_req_rd = 1; l1_req_rd_addr = 26'h7;
        tick();
        check("l1_acc_busy", 128'(l1_busy), 128'(1));
        check("l1_acc_rdy", 128'(l1_rd_ready), 128'(0));
        tick();
        check("l1_rdy", 128'(l1_rd_ready), 128'(1));
        check("l1_data", l1_rd_line, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
        tick();
        check("l1_rdy_drop", 128'(l1_rd_ready), 128'(0));
        check("l1_turn_idle", 128'(l1_busy), 128'(0));
        tick();
        check("l1_reaccept", 128'(l1_busy), 128'(1));
        tick();
        check("l1_rdy2", 128'(l1_rd_ready), 128'(1));
        l1_req_rd = 0;
        tick();
        check("l1_end_idle", 128'(l1_busy), 128'(0));

        // Randomized traffic over a small pool of lines with aliased addresses.
        for (int i = 0; i < 8; i++) idx_pool[i] = int'($urandom_range(ML - 1, 0));
        for (int i = 0; i < 40; i++) begin
            int id;
            logic [25:0] a;
            id = idx_pool[$urandom_range(7, 0)];
            a  = (26'($urandom) & ~26'(ML - 1)) | 26'(id);
            if ($urandom_range(1, 0) == 1 && model_mem.exists(id))
                do_read(a);
            else
                do_write(a, rand128());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
